// File: rtl/typing_pkg.sv
// typing_pkg
// Shared definitions for the typing-trainer keyboard stages.
//   state_t    : sequencer state encoding (2'b11 is unused and recovers to IDLE)
//   PROMPT_LEN : number of characters in one prompt
//   SEL_LAST   : select value of the final prompt character
//   CHAR_W_DEF : default width of key codes and prompt characters
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int         PROMPT_LEN = 4;
  localparam logic [1:0] SEL_LAST   = 2'd3;
  localparam int         CHAR_W_DEF = 8;

endpackage

// File: rtl/key_edge.sv
// key_edge
// Rising-edge detector for a key-available strobe. The delayed copy is
// registered every cycle, so a level held high yields exactly one edge.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low clear of the delay register
//   din     : level or pulse to watch
//   rise    : combinational, high in the first cycle din is seen high
module key_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q_reg <= 1'b0;
    end else begin
      din_q_reg <= din;
    end
  end

  assign rise = din & ~din_q_reg;

endmodule

// File: rtl/prompt_sequencer.sv
// prompt_sequencer
// Walks the player through a four-character prompt by driving the select of
// the prompt mux and comparing each new keystroke with the character that mux
// returns. Advances only on a correct key, counts misses (saturating) and
// flags completion.
// Optional feature: define PROMPT_TIMEOUT_EN to add a per-character idle
// timer; when it expires it counts as a miss.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : pulse, begins or restarts a prompt (beats a coincident key)
//   key_valid    : key strobe, only its rising edge is used
//   key_code     : key code sampled on the key_valid rising edge
//   expected     : prompt character selected by sel (from the mux)
//   sel          : registered prompt-mux select
//   busy / done  : high in RUN / DONE
//   hit / miss   : one-cycle pulses for a correct / wrong (or timed-out) key
//   err_count    : saturating miss count for the current prompt
module prompt_sequencer
  import typing_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int ERR_W   = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              key_valid,
  input  logic [CHAR_W-1:0] key_code,
  input  logic [CHAR_W-1:0] expected,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              miss,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_reg;
  logic [1:0]       sel_reg;
  logic [ERR_W-1:0] err_reg;
  logic             hit_reg;
  logic             miss_reg;
  logic             busy_reg;
  logic             done_reg;

  logic key_edge_w;
  logic key_match;
  logic timeout_w;

  key_edge u_key_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (key_valid),
    .rise    (key_edge_w)
  );

  assign key_match = (key_code == expected);

`ifdef PROMPT_TIMEOUT_EN
  localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_reg;

  // Expiry only matters in RUN; the FSM ignores it elsewhere.
  assign timeout_w = (timer_reg == '0);

  // Reload on any start, on every key edge in RUN and on expiry; frozen
  // outside RUN so an idle or finished prompt never times out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_reg <= '0;
    end else if (start) begin
      timer_reg <= TMR_LOAD;
    end else if (state_reg == RUN) begin
      if (key_edge_w || timeout_w) begin
        timer_reg <= TMR_LOAD;
      end else begin
        timer_reg <= timer_reg - 1'b1;
      end
    end
  end
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      err_reg   <= '0;
      hit_reg   <= 1'b0;
      miss_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      hit_reg  <= 1'b0;
      miss_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= RUN;
            sel_reg   <= '0;
            err_reg   <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            // Restart: any coincident key is discarded without a pulse.
            sel_reg <= '0;
            err_reg <= '0;
          end else if (key_edge_w) begin
            if (key_match) begin
              hit_reg <= 1'b1;
              if (sel_reg == SEL_LAST) begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                sel_reg <= sel_reg + 2'd1;
              end
            end else begin
              miss_reg <= 1'b1;
              if (err_reg != ERR_MAX) err_reg <= err_reg + 1'b1;
            end
          end else if (timeout_w) begin
            miss_reg <= 1'b1;
            if (err_reg != ERR_MAX) err_reg <= err_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          sel_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_reg;
  assign err_count = err_reg;
  assign hit       = hit_reg;
  assign miss      = miss_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_prompt_sequencer.sv
// tb_prompt_sequencer
// Self-checking bench: a mux4 model feeds "CAFE" back on expected, and a
// behavioural model (prompt position, miss tally, idle-cycle count) predicts
// every output after every clock. Directed scenarios plus randomized keys.
module tb_prompt_sequencer;

  localparam int CHAR_W  = 8;
  localparam int ERR_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              key_valid;
  logic [CHAR_W-1:0] key_code;
  logic [CHAR_W-1:0] expected;
  logic [1:0]        sel;
  logic              busy;
  logic              done;
  logic              hit;
  logic              miss;
  logic [ERR_W-1:0]  err_count;

  logic [CHAR_W-1:0] prompt [4];

  always #5 clk = ~clk;

  // mux4 model: purely combinational from sel
  assign expected = prompt[sel];

  prompt_sequencer #(
    .CHAR_W  (CHAR_W),
    .ERR_W   (ERR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_valid (key_valid),
    .key_code  (key_code),
    .expected  (expected),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .miss      (miss),
    .err_count (err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_run, m_done, m_hit, m_miss, m_prev_kv;
  int m_pos, m_err, m_idle;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_hit = 0; m_miss = 0; m_prev_kv = 0;
    m_pos = 0; m_err = 0; m_idle = 0;
  endtask

  task automatic check_outputs();
    check_val("sel",  32'(sel),       32'(m_pos));
    check_val("err",  32'(err_count), 32'(m_err));
    check_val("hit",  32'(hit),       32'(m_hit));
    check_val("miss", 32'(miss),      32'(m_miss));
    check_val("busy", 32'(busy),      32'(m_run));
    check_val("done", 32'(done),      32'(m_done));
  endtask

  task automatic add_miss();
    m_miss = 1;
    if (m_err < ERR_MAX) m_err++;
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare #1 later.
  task automatic cycle(input bit st, input bit kv, input logic [CHAR_W-1:0] kc);
    bit edge_k;
    @(negedge clk);
    start = st; key_valid = kv; key_code = kc;
    @(posedge clk);
    edge_k    = kv && !m_prev_kv;
    m_prev_kv = kv;
    m_hit = 0; m_miss = 0;
    if (st) begin
      m_run = 1; m_done = 0; m_pos = 0; m_err = 0; m_idle = 0;
    end else if (m_run) begin
      if (edge_k) begin
        m_idle = 0;
        if (kc == prompt[m_pos]) begin
          m_hit = 1;
          if (m_pos == 3) begin
            m_run = 0; m_done = 1;
          end else begin
            m_pos++;
          end
        end else begin
          add_miss();
        end
      end else begin
`ifdef PROMPT_TIMEOUT_EN
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_idle = 0;
          add_miss();
        end
`endif
      end
    end
    #1;
    check_outputs();
    $display("[TB] st=%0b kv=%0b kc=%02h sel=%0d err=%0d hit=%0b miss=%0b busy=%0b done=%0b",
             st, kv, kc, sel, err_count, hit, miss, busy, done);
  endtask

  task automatic press(input logic [CHAR_W-1:0] kc);
    cycle(0, 1, kc);
    cycle(0, 0, kc);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    start = 0; key_valid = 0;
    #2 reset_n = 0;
    #1;
    check_val("rst_sel",  32'(sel),       0);
    check_val("rst_err",  32'(err_count), 0);
    check_val("rst_hit",  32'(hit),       0);
    check_val("rst_miss", 32'(miss),      0);
    check_val("rst_busy", 32'(busy),      0);
    check_val("rst_done", 32'(done),      0);
    $display("[TB] async reset: sel=%0d err=%0d busy=%0b done=%0b", sel, err_count, busy, done);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  int cnt;
  bit kv_r;
  logic [CHAR_W-1:0] kc_r;

  initial begin
    prompt[0] = 8'h43; prompt[1] = 8'h41; prompt[2] = 8'h46; prompt[3] = 8'h45;
    reset_n = 0; start = 0; key_valid = 0; key_code = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset_n = 1;
    cycle(0, 1, 8'h43);   // key edge in IDLE is ignored
    cycle(0, 0, 8'h00);

    // "CAFE" typed correctly
    cycle(1, 0, 8'h00);
    press(8'h43); press(8'h41); press(8'h46); press(8'h45);
    check_val("cafe_done", 32'(done), 1);
    press(8'h43);         // ignored in DONE

    // one wrong key
    cycle(1, 0, 8'h00);
    press(8'h43); press(8'h58); press(8'h41); press(8'h46); press(8'h45);
    check_val("cafe_err1", 32'(err_count), 1);

    // held key gives a single hit, then 5 wrong keys saturate
    cycle(1, 0, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'h43);
      cnt += int'(hit);
    end
    cycle(0, 0, 8'h00);
    check_val("held_hits", cnt, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 8'h00);
      cnt += int'(miss);
      cycle(0, 0, 8'h00);
    end
    check_val("sat_misses", cnt, 5);
    check_val("sat_err", 32'(err_count), ERR_MAX);

    // start and correct key edge together at sel=2
    cycle(1, 0, 8'h00);
    press(8'h43); press(8'h41);
    cycle(1, 1, 8'h46);
    check_val("st_key_sel", 32'(sel), 0);
    check_val("st_key_hit", 32'(hit), 0);
    cycle(0, 0, 8'h00);

    // idle behaviour in RUN
    cycle(1, 0, 8'h00);
    cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle(0, 0, 8'h00);
      cnt += int'(miss);
    end
`ifdef PROMPT_TIMEOUT_EN
    check_val("tmo_miss", cnt, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h43);   // lands on the expiry cycle: hit only
    check_val("tmo_key_hit", 32'(hit), 1);
    check_val("tmo_key_miss", 32'(miss), 0);
    cycle(0, 0, 8'h00);
`else
    for (int i = 0; i < 1000; i++) begin
      cycle(0, 0, 8'h00);
      cnt += int'(miss);
    end
    check_val("idle_nomiss", cnt, 0);
`endif

    // mid-RUN reset with sel=2, err=3
    cycle(1, 0, 8'h00);
    press(8'h11); press(8'h22); press(8'h33);
    press(8'h43); press(8'h41);
    check_val("pre_rst_sel", 32'(sel), 2);
    check_val("pre_rst_err", 32'(err_count), 3);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        kv_r = ($urandom_range(0, 2) == 0);
        kc_r = ($urandom_range(0, 9) < 7) ? prompt[m_pos] : CHAR_W'($urandom);
        cycle($urandom_range(0, 39) == 0, kv_r, kc_r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prompt_sequencer.md
# prompt_sequencer

Drives the 2-bit `control` select of the four-character prompt multiplexer (`mux4`) and checks keystrokes against the character that multiplexer returns. It walks the player through a four-character prompt, advancing only on correct keys. It counts misses and reports completion to the score/display logic. It is the stage directly upstream of the prompt mux and also consumes the mux's output.

## Interface
Parameters:
- `CHAR_W`, default 8: width of key codes and prompt characters.
- `ERR_W`, default 4: width of the miss counter.
- `TIMEOUT`, default 50_000_000: idle cycles allowed per character. Used only when `PROMPT_TIMEOUT_EN` is defined; must be ≥ 2.

Ports (clock and reset first):
- `clk`  input  1: single clock. All state changes on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: one-cycle pulse that begins or restarts a prompt.
- `key_valid`  input  1: key-available level or pulse. Only its rising edge is used.
- `key_code`  input  CHAR_W: code of the key pressed. Sampled on the `key_valid` rising edge.
- `expected`  input  CHAR_W: prompt character currently selected. Connected to the mux4 `out` bus; combinational from `sel`.
- `sel`  output  2: registered select, connected to mux4 `control`.
- `busy`  output  1: high in RUN.
- `done`  output  1: high in DONE.
- `hit`  output  1: one-cycle pulse on a correct key.
- `miss`  output  1: one-cycle pulse on a wrong key or a timeout.
- `err_count`  output  ERR_W: number of misses in the current prompt. Saturating.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** While `reset_n` is low, all of the following are 0: `sel`, `err_count`, `hit`, `miss`, `busy`, `done`, the edge register and the timer. State goes to IDLE. This holds even mid-prompt; no partial result survives.
- **Key edge:** `key_edge = key_valid & ~key_valid_q`. `key_valid_q` is registered every cycle in every state. A key held high produces exactly one edge.
- **IDLE:**
  - `start` → RUN, `sel`=0, `err_count`=0, timer loaded.
  - Key edges are ignored.
- **RUN, on `key_edge`:**
  - If `key_code == expected` (full CHAR_W compare): `hit` pulses.
    - If `sel`==3 → DONE and `sel` holds at 3.
    - Otherwise `sel` increments by 1. It never wraps inside RUN.
  - Otherwise: `miss` pulses, `err_count` increments, and `sel` is unchanged.
- **Saturation:** `err_count` stops at 2^ERR_W−1. `miss` still pulses when saturated.
- **DONE:**
  - Outputs hold.
  - `start` → RUN with `sel`=0 and `err_count`=0.
  - Key edges are ignored.
- **Simultaneous `start` and `key_edge`:** `start` wins in every state; the key is discarded.
- **`start` during RUN:** restarts the prompt: `sel`=0, `err_count`=0, timer reloaded, and no `hit`/`miss` pulse.

## Timing
- `expected` is sampled in the same cycle as `key_edge`. Upstream must hold `expected` valid whenever `sel` is stable; mux4 is purely combinational.
- `hit`/`miss` are registered. They are high for exactly the one cycle after the edge at which the key was accepted.
- `sel`, `err_count`, `busy` and `done` update on that same edge. `sel` therefore changes one cycle before the next comparison can occur.
- Minimum spacing between key edges is 2 cycles, set by the edge detector. Back-to-back edges 2 cycles apart must both be processed.
- `done` rises on the edge after the fourth correct key and stays high until `start` or reset.

## Configuration
- **`PROMPT_TIMEOUT_EN` defined:**
  - A down-counter wide enough for `TIMEOUT` is loaded with `TIMEOUT−1` on entry to RUN and on every accepted key edge.
  - It decrements each RUN cycle. On reaching 0, it acts as a miss: `miss` pulses, `err_count` increments (saturating), `sel` is unchanged, and the counter reloads.
  - A key edge in the same cycle as expiry wins; the timeout is dropped.
  - The counter is frozen in IDLE and DONE.
- **`PROMPT_TIMEOUT_EN` undefined:** no counter exists, `TIMEOUT` is unused, and misses come only from wrong keys.

## Structure
- **Shared package `typing_pkg`:**
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - `PROMPT_LEN`=4 and `SEL_LAST`=2'd3.
  - Default `CHAR_W`.
- **Sub-module `key_edge`:** rising-edge detector with an asynchronous active-low clear. It is reused later by other keyboard-facing stages.
- **Top level:** the FSM, `sel`/`err_count` registers and the optional timer stay in `prompt_sequencer`.

## Test plan
- Reset mid-RUN, with `sel`=2 and `err_count`=3: assert `reset_n`=0 → all outputs 0 and state IDLE immediately, asynchronously before the next clock edge.
- Prompt "CAFE" via a mux4 model: `start`, then key edges 0x43, 0x41, 0x46, 0x45 → `hit` ×4, `sel` 0→1→2→3, `done`=1, `err_count`=0.
- Same prompt, keys 0x43, 0x58, 0x41, 0x46, 0x45 → one `miss` after 0x58, `sel` stays 1 across it, `done` with `err_count`=1.
- `key_valid` held high for 10 cycles with the correct key → exactly one `hit`. With ERR_W=2, 5 wrong keys → `err_count`=3 and 5 `miss` pulses.
- `start` and a correct key edge in the same cycle during RUN at `sel`=2 → `sel`=0, `err_count`=0, no `hit`.
- With `PROMPT_TIMEOUT_EN` and `TIMEOUT`=8: no key for 8 RUN cycles → one `miss`. Key edge on the expiry cycle → `hit` only. Without the macro: no miss after 1000 idle cycles.
